// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction field positions, reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StFlush
  } fetch_state_e;

  // Instruction field bit positions, shared with the decoder.
  localparam int unsigned IrSelHi = 7;
  localparam int unsigned IrSelLo = 6;
  localparam int unsigned IrPM    = 5;
  localparam int unsigned IrWe    = 4;
  localparam int unsigned IrImSt  = 3;
  localparam int unsigned IrA     = 2;
  localparam int unsigned IrB     = 1;
  localparam int unsigned IrC     = 0;

  localparam int unsigned ResetPcDefault = 0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding byte reads, IR and decoded fields.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ResetPcDefault)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [1:0]        select,
  output logic              p_m,
  output logic              we,
  output logic              im_st,
  output logic              a,
  output logic              b,
  output logic              c
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;

  // Request is gated by rst so nothing is issued while the block is held in reset.
  assign imem_req  = (state_q == StReq) && !rst;
  assign imem_addr = pc_q;

  assign ir_valid = ir_valid_q;
  assign ir_pc    = ir_pc_q;
  assign select   = ir_q[IrSelHi:IrSelLo];
  assign p_m      = ir_q[IrPM];
  assign we       = ir_q[IrWe];
  assign im_st    = ir_q[IrImSt];
  assign a        = ir_q[IrA];
  assign b        = ir_q[IrB];
  assign c        = ir_q[IrC];

  // Next-state logic; jump outranks every event, and a fetch already issued is squashed.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    unique case (state_q)
      StReq: begin
        if (jump) begin
          pc_d       = jump_addr;
          ir_valid_d = 1'b0;
          state_d    = StFlush;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (jump) begin
          pc_d       = jump_addr;
          ir_valid_d = 1'b0;
          // Data arriving with the jump is dropped; otherwise it is still owed to us.
          state_d    = imem_valid ? StReq : StFlush;
        end else if (imem_valid) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          ir_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (jump) begin
          pc_d       = jump_addr;
          ir_valid_d = 1'b0;
          state_d    = StReq;
        end else if (!stall) begin
          ir_valid_d = 1'b0;
          state_d    = StReq;
        end
      end
      StFlush: begin
        if (jump) begin
          pc_d       = jump_addr;
          ir_valid_d = 1'b0;
        end
        if (imem_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       stall;
  logic       jump;
  logic [7:0] jump_addr;
  logic       ir_valid;
  logic [7:0] ir_pc;
  logic [1:0] select;
  logic       p_m, we, im_st, a, b, c;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall      (stall),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .ir_valid   (ir_valid),
    .ir_pc      (ir_pc),
    .select     (select),
    .p_m        (p_m),
    .we         (we),
    .im_st      (im_st),
    .a          (a),
    .b          (b),
    .c          (c)
  );

  always #5 clk = ~clk;

  // Memory model: answers each request lat cycles later, once; cleared by rst.
  logic [7:0] mem [256];
  int         lat = 1;
  int         cnt = 0;
  logic       busy = 1'b0;
  logic [7:0] maddr = '0;

  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
  end

  always @(negedge clk) begin
    #2;
    imem_valid = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else if (busy) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem[maddr];
        busy       = 1'b0;
      end
    end else if (imem_req) begin
      busy  = 1'b1;
      cnt   = lat;
      maddr = imem_addr;
    end
  end

  typedef struct {
    logic       r, s, j;
    logic [7:0] ja;
    logic       req;
    logic [7:0] addr;
    logic       irv;
    logic [7:0] irpc;
    logic [7:0] ir;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic j, logic [7:0] ja, logic req,
                              logic [7:0] addr, logic irv, logic [7:0] irpc, logic [7:0] ir);
    vec_t v;
    v.r = r; v.s = s; v.j = j; v.ja = ja; v.req = req;
    v.addr = addr; v.irv = irv; v.irpc = irpc; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [7:0] addr,
                            input logic irv, input logic [7:0] irpc, input logic [7:0] ir);
    chk({tag, " imem_req"}, 32'(imem_req), 32'(req));
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, " ir_valid"}, 32'(ir_valid), 32'(irv));
    chk({tag, " ir_pc"}, 32'(ir_pc), 32'(irpc));
    chk({tag, " fields"}, 32'({select, p_m, we, im_st, a, b, c}), 32'(ir));
  endtask

  // Advance to the next cycle and drive this cycle's inputs; outputs settle by #1.
  task automatic drive(input logic r, input logic s, input logic j, input logic [7:0] ja);
    @(negedge clk);
    rst = r; stall = s; jump = j; jump_addr = ja;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  vec_t tbl[18];

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hC5;
    mem[8'h01] = 8'h3A;
    mem[8'h02] = 8'h81;
    mem[8'h10] = 8'hE7;
    mem[8'h40] = 8'h96;
    mem[8'hFF] = 8'h5A;

    // Reset release, 4-cycle stall, jump from HOLD to 0xFF, PC wrap to 0x00.
    //              r     s     j     ja     req   addr   irv   irpc   ir
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 8'hC5);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 8'hC5);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 8'hC5);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 8'hC5);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 8'hC5);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'hC5);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00, 8'hC5);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h01, 8'h3A);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h01, 8'h3A);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 8'h01, 8'h3A);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h03, 1'b1, 8'h02, 8'h81);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h02, 8'h81);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h02, 8'h81);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h5A);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h5A);

    lat = 1;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].j, tbl[i].ja);
      expect_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].irv,
                 tbl[i].irpc, tbl[i].ir);
    end

    // Jump to 0x40 during WAIT with 3-cycle memory: flush, data discarded.
    lat = 3;
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c1", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h40); expect_out("flush c2", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c3", 1'b0, 8'h40, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c4", 1'b0, 8'h40, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c5", 1'b1, 8'h40, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c6", 1'b0, 8'h40, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c7", 1'b0, 8'h40, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c8", 1'b0, 8'h40, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("flush c9", 1'b0, 8'h41, 1'b1, 8'h40, 8'h96);

    // Jump coinciding with imem_valid drops the data; then jump from HOLD.
    lat = 1;
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("jv c1", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h10); expect_out("jv c2", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("jv c3", 1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("jv c4", 1'b0, 8'h10, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h10); expect_out("jv c5", 1'b0, 8'h11, 1'b1, 8'h10, 8'hE7);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("jv c6", 1'b1, 8'h10, 1'b0, 8'h10, 8'hE7);

    // Reset asserted mid-WAIT after two completed fetches; fetch restarts at RESET_PC.
    lat = 1;
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c1", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c2", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c3", 1'b0, 8'h01, 1'b1, 8'h00, 8'hC5);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c4", 1'b1, 8'h01, 1'b0, 8'h00, 8'hC5);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c5", 1'b0, 8'h01, 1'b0, 8'h00, 8'hC5);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c6", 1'b0, 8'h02, 1'b1, 8'h01, 8'h3A);
    lat = 3;
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c7", 1'b1, 8'h02, 1'b0, 8'h01, 8'h3A);
    drive(1'b1, 1'b0, 1'b0, 8'h00); expect_out("rw c8", 1'b0, 8'h02, 1'b0, 8'h01, 8'h3A);
    drive(1'b1, 1'b0, 1'b0, 8'h00); expect_out("rw c9", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    lat = 1;
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c10", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c11", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00); expect_out("rw c12", 1'b0, 8'h01, 1'b1, 8'h00, 8'hC5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit CPU, directly upstream of the instruction decoder. It holds the program counter, issues byte reads to instruction memory, captures the returned byte in an instruction register, and presents it split into the decoder's fields: `select`, `p_m`, `we`, `im_st`, `a`, `b`, `c`. Jumps from the execute side redirect the PC and squash any in-flight fetch.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction memory address / PC width.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports (one clock `clk`; `rst` is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `imem_req`  out  1  read request, one-cycle pulse per fetch.
- `imem_addr`  out  ADDR_W  read address, equals PC.
- `imem_rdata`  in  8  returned instruction byte.
- `imem_valid`  in  1  `imem_rdata` valid; arrives ≥1 cycle after `imem_req`, exactly once per request.
- `stall`  in  1  decoder/execute not ready to consume the IR.
- `jump`  in  1  redirect request, single-cycle pulse.
- `jump_addr`  in  ADDR_W  redirect target.
- `ir_valid`  out  1  IR holds a live instruction.
- `ir_pc`  out  ADDR_W  address the IR was fetched from.
- `select`  out  2  IR[7:6].
- `p_m`  out  1  IR[5].
- `we`  out  1  IR[4].
- `im_st`  out  1  IR[3].
- `a`, `b`, `c`  out  1 each  IR[2], IR[1], IR[0].

## Operation
- Field outputs are wires from the IR; they are meaningful only while `ir_valid`=1.
- FSM states: REQ, WAIT, HOLD, FLUSH.
  - REQ: `imem_req`=1, `imem_addr`=PC. Next state: WAIT, or FLUSH if `jump`=1.
  - WAIT: on `imem_valid`, load IR←`imem_rdata`, `ir_pc`←PC, PC←PC+1, `ir_valid`←1, go to HOLD. Otherwise stay.
  - HOLD: `ir_valid`=1. If `stall`=0, the instruction is consumed this cycle: `ir_valid`←0, go to REQ. If `stall`=1, stay with the IR unchanged.
  - FLUSH: wait for the pending `imem_valid`, discard its data, then go to REQ. Issues no request.
- Jump has priority over every other event except reset. It loads PC←`jump_addr` and clears `ir_valid` next cycle.
  - From HOLD: go to REQ.
  - From REQ or WAIT with no `imem_valid` this cycle: go to FLUSH.
  - From WAIT with `imem_valid` the same cycle: discard the data, go to REQ.
  - From FLUSH: update PC and stay. If `imem_valid` arrives the same cycle, go to REQ.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 → 0x00, no flag.
- At most one memory request is outstanding at any time.
- Reset (any state, including mid-fetch): PC←`RESET_PC`, state←REQ, IR←0, `ir_pc`←0, `ir_valid`←0. `imem_req` is gated with `rst`, so it is 0 while `rst`=1.
- Memory must not return a stale `imem_valid` after reset. The system resets memory together with this block.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `ir_valid`=0, `ir_pc`=0, all field outputs 0.
- First `imem_req` occurs in the first cycle after `rst` deasserts.
- `imem_req` and `imem_addr` are combinational from state/PC.
- `ir_valid` is registered, rising the cycle after `imem_valid`.
- With 1-cycle memory and no stall: REQ, WAIT (valid), HOLD (consumed). This gives 3 cycles per instruction.
- A jump takes effect on `imem_addr` in the next REQ: ≥1 cycle from HOLD, ≥2 cycles via FLUSH.

## Structure
- Shared `cpu_pkg` holds:
  - the fetch state enum;
  - instruction field bit-position constants (SEL 7:6, P_M 5, WE 4, IM_ST 3, A 2, B 1, C 0), shared with the decoder;
  - the `RESET_PC` default.
- Single module; no sub-module is warranted.

## Test plan
- Reset release, 1-cycle memory returning 0xC5 at address 0, `stall`=0:
  - `imem_req` at cycle 1 with addr 0;
  - `ir_valid` at cycle 3 with `select`=3, `p_m`=0, `we`=0, `im_st`=0, `a`=1, `b`=0, `c`=1, `ir_pc`=0;
  - next request has addr 1.
- `stall` held 4 cycles in HOLD → IR and `ir_valid` unchanged, no `imem_req`; the request for the next address is issued the cycle after `stall` falls.
- PC at 0xFF, fetch completes → `ir_pc`=0xFF, next `imem_addr`=0x00.
- Jump to 0x40 in WAIT with 3-cycle memory latency → state FLUSH; the returned byte is discarded (`ir_valid` stays 0); next `imem_req` has addr 0x40.
- Jump to 0x10 in the same cycle as `imem_valid` → data dropped, next `imem_req` has addr 0x10. Also: jump in HOLD → `ir_valid` falls next cycle, request to 0x10 issued.
- `rst` asserted during WAIT → next cycle all outputs are at reset values and `imem_req`=0 while `rst`=1; after release, fetch restarts at `RESET_PC`.
